// File: rtl/fpga_reset_sequencer.sv
// Reset request sequencer ahead of fpga_clock_reset.
// Merges POR and host requests, enforces widths, waits on feedback.
module fpga_reset_sequencer #(
    parameter int MIN_RESET_CYCLES = 16,
    parameter int MIN_RUN_CYCLES   = 16,
    parameter int ACK_TIMEOUT      = 1024,
    parameter int SYNC_STAGES      = 2,
    parameter int CNT_W            = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_rst_in,
    input  logic             err_clr_in,
    input  logic             rst_fb_in,
    output logic             rst_out,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] rst_count
);

    localparam int MAX_A = (MIN_RESET_CYCLES > MIN_RUN_CYCLES) ?
                           MIN_RESET_CYCLES : MIN_RUN_CYCLES;
    localparam int MAX_C = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(MIN_RESET_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(MIN_RUN_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        RUN,
        ASSERT,
        WAIT_ASSERT_ACK,
        RELEASE,
        COOLDOWN
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   pending;
    logic [SYNC_STAGES-1:0] fb_sync;
    logic                   fb;

    assign fb = fb_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            fb_sync <= '0;
        end else begin
            fb_sync <= {fb_sync[SYNC_STAGES-2:0], rst_fb_in};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ASSERT;
            cnt         <= '0;
            pending     <= 1'b0;
            rst_out     <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            rst_count   <= '0;
        end else begin
            done <= 1'b0;
            if (err_clr_in) begin
                timeout_err <= 1'b0;
            end
            unique case (state)
                RUN: begin
                    if (req_rst_in || pending) begin
                        state   <= ASSERT;
                        cnt     <= '0;
                        pending <= 1'b0;
                        rst_out <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (cnt == RST_LAST) begin
                        state <= WAIT_ASSERT_ACK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_ASSERT_ACK: begin
                    // Release even on timeout so the system is never stuck.
                    if (!fb || cnt == TO_LAST) begin
                        state   <= RELEASE;
                        cnt     <= '0;
                        rst_out <= 1'b1;
                        if (fb) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (req_rst_in) begin
                        pending <= 1'b1;
                    end
                    if (fb || cnt == TO_LAST) begin
                        state <= COOLDOWN;
                        cnt   <= '0;
                        if (!fb) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (req_rst_in) begin
                        pending <= 1'b1;
                    end
                    if (cnt == RUN_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (rst_count != {CNT_W{1'b1}}) begin
                            rst_count <= rst_count + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ASSERT;
                    cnt     <= '0;
                    rst_out <= 1'b0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/fpga_reset_sequencer.md
Name: fpga_reset_sequencer

Overview:
Reset request sequencer placed directly upstream of fpga_clock_reset; its rst_out drives that block's active-low rst_in.
- Merges the power-on reset and host/software reset requests into a single active-low reset.
- Enforces a minimum assertion width and a minimum run time between resets.
- Closes the loop on the downstream rst_out (fed back as rst_fb_in) so each sequence completes only after the gated domain has entered and left reset.

Parameters:
MIN_RESET_CYCLES, 16, minimum clk_in cycles rst_out is held low per sequence (>=1)
MIN_RUN_CYCLES, 16, cycles after release before a new sequence may start (>=1)
ACK_TIMEOUT, 1024, max cycles waited for each feedback edge before flagging an error
SYNC_STAGES, 2, flops in the rst_fb_in synchroniser (>=2)
CNT_W, 16, width of the completed-sequence counter

Ports:
clk_in  input  1  free-running clock, same clock as fpga_clock_reset clk_in
rst_in  input  1  asynchronous active-low reset (power-on)
req_rst_in  input  1  reset request, sampled each cycle; pulse or level
err_clr_in  input  1  clears timeout_err
rst_fb_in  input  1  downstream rst_out (active-low, 1 = running); asynchronous, synchronised internally
rst_out  output  1  active-low reset to fpga_clock_reset rst_in
busy  output  1  high while a sequence is in progress
done  output  1  one-cycle pulse when a sequence completes
timeout_err  output  1  sticky: a feedback edge did not arrive within ACK_TIMEOUT
rst_count  output  CNT_W  number of completed sequences, saturating

Behaviour:
Reset values (rst_in low):
- rst_out=0, busy=1, done=0, timeout_err=0, rst_count=0, pending=0.
- Synchroniser flops reset to 0; state=ASSERT; cycle counter=0.
- Asynchronous assertion takes effect immediately; release is synchronous to clk_in.
- Release therefore runs a full power-on sequence.

All outputs are registered.

State machine:
- RUN: rst_out=1, busy=0.
  - req_rst_in=1 or pending=1 -> ASSERT.
  - rst_out goes low on the edge that samples the request, so it is low in the following cycle.
- ASSERT: rst_out=0. Count MIN_RESET_CYCLES cycles -> WAIT_ASSERT_ACK.
  - Pending is cleared on entry.
  - Requests in ASSERT and WAIT_ASSERT_ACK are merged into the current sequence and ignored.
- WAIT_ASSERT_ACK: rst_out=0. Wait for synchronised rst_fb == 0 -> RELEASE.
  - If ACK_TIMEOUT cycles pass first: set timeout_err and go -> RELEASE anyway.
- RELEASE: rst_out=1. Wait for synchronised rst_fb == 1 -> COOLDOWN.
  - Timeout: set timeout_err, -> COOLDOWN.
- COOLDOWN: rst_out=1. Count MIN_RUN_CYCLES cycles, then on exit:
  - done=1 for one cycle.
  - rst_count increments, saturating at 2^CNT_W-1.
  - -> RUN.
- busy=1 in every state except RUN.

Pending requests:
- A request in RELEASE or COOLDOWN sets the single pending bit; multiple requests collapse into one.
- Pending is serviced on the first RUN cycle, so RUN lasts exactly one cycle.

Timeout counter:
- Clears on entry to each wait state.
- Timeout occurs when the counter reaches ACK_TIMEOUT-1.

err_clr_in:
- Clears timeout_err one cycle later.
- If err_clr_in and a new timeout occur in the same cycle, set wins.

Timing guarantees:
- rst_out low time >= MIN_RESET_CYCLES plus feedback latency.
- rst_out high time between sequences >= MIN_RUN_CYCLES plus release-ack latency.

rst_fb_in is treated as asynchronous: no combinational path from rst_fb_in to any output.

Test Plan:
- POR: rst_in low 5 cycles then high; feedback model echoes rst_out after a 6-cycle delay. Required response:
  - rst_out low for >=16 cycles and stays low until the synchronised feedback is low.
  - rst_out rises, then done pulses after 16 COOLDOWN cycles.
  - rst_count=1, busy=0, timeout_err=0.
- Single-cycle req_rst_in pulse in RUN: rst_out=0 the next cycle, busy=1; the full sequence repeats; rst_count=2.
- Requests during a sequence:
  - Pulse in ASSERT: merged, exactly one done.
  - Pulse in COOLDOWN: pending set; new ASSERT starts one cycle after done; RUN lasts 1 cycle; count increments by 2 in total.
- Stuck feedback, rst_fb_in held 1: after 1024 WAIT_ASSERT_ACK cycles, timeout_err=1 and rst_out released; sequence completes with done.
  - err_clr_in pulse -> timeout_err=0.
  - Simultaneous err_clr_in with a timeout -> timeout_err stays 1.
- Saturation with CNT_W=2: 5 sequences -> rst_count reads 1, 2, 3, 3, 3.
- rst_in asserted mid-RELEASE: rst_out=0 immediately (asynchronous), rst_count=0, done never pulses. After release, a fresh POR sequence runs.
